// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the MIPS program counter and sequences instruction fetch.
// Each cycle the next PC is one of four things: the sequential value from the
// external fetch adder, a branch or jump target, the held PC (stall), or the
// frozen PC (halt). The run mode (free-running or single-step) is chosen when
// the core leaves IDLE.
// Optional feature: define PC_SEQ_CYCLE_COUNT_EN to build the run-cycle counter
// behind o_cycle_count. Without it, o_cycle_count is tied to zero and the port
// list stays the same.
module pc_sequencer #(
    parameter int             LEN      = 32,
    parameter logic [LEN-1:0] RESET_PC = '0,
    parameter logic [LEN-1:0] INC      = LEN'(4)
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic           i_debug_mode,
    input  logic           i_step,
    input  logic           i_stall,
    input  logic           i_branch_taken,
    input  logic [LEN-1:0] i_branch_addr,
    input  logic           i_jump,
    input  logic [LEN-1:0] i_jump_addr,
    input  logic           i_halt,
    input  logic [LEN-1:0] i_adder_sum,
    output logic [LEN-1:0] o_pc,
    output logic           o_adder_enable,
    output logic           o_fetch_valid,
    output logic           o_halted,
    output logic [1:0]     o_state,
    output logic [LEN-1:0] o_cycle_count
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_STEP   = 2'b10;
    localparam logic [1:0] ST_HALTED = 2'b11;

    // Instruction addresses are word aligned, so redirect targets drop the low two bits.
    localparam logic [LEN-1:0] WORD_MASK = ~LEN'(3);

    logic [1:0]     state_q, state_d;
    logic [LEN-1:0] pc_q, pc_d;
    logic           advance;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A halt takes effect only inside an advance slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = i_debug_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_STEP: begin
                if (i_step && i_halt) begin
                    state_d = ST_HALTED;
                end
            end
            default: state_d = ST_HALTED;
        endcase
    end

    // Output and next-PC selection. Priority is halt, branch, jump, stall, sequential.
    // A branch wins over a jump in the same cycle because the branch belongs to the
    // older instruction. Any redirect flushes past a stall.
    always_comb begin
        advance        = (state_q == ST_RUN) || ((state_q == ST_STEP) && i_step);
        pc_d           = pc_q;
        o_adder_enable = 1'b0;
        o_fetch_valid  = advance && !i_stall;
        if (advance) begin
            if (i_halt) begin
                pc_d = pc_q;
            end else if (i_branch_taken) begin
                pc_d = i_branch_addr & WORD_MASK;
            end else if (i_jump) begin
                pc_d = i_jump_addr & WORD_MASK;
            end else if (i_stall) begin
                pc_d = pc_q;
            end else begin
                pc_d           = i_adder_sum;
                o_adder_enable = 1'b1;
            end
        end
    end

    // Program counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef PC_SEQ_CYCLE_COUNT_EN
    logic [LEN-1:0] cnt_q, cnt_d;

    // Count every advance slot, including stalled ones; the counter wraps modulo 2^LEN.
    always_comb begin
        cnt_d = advance ? cnt_q + LEN'(1) : cnt_q;
    end

    // Run-cycle counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cycle_count = cnt_q;
`else
    assign o_cycle_count = '0;
`endif

    assign o_pc     = pc_q;
    assign o_state  = state_q;
    assign o_halted = (state_q == ST_HALTED);

    // The external fetch adder must return o_pc + INC whenever the sequential path is used.
    a_adder_sum: assert property (@(posedge i_clk) disable iff (i_reset)
        o_adder_enable |-> (i_adder_sum == o_pc + INC));

endmodule
